// File: rtl/sd_spi_master_if.sv
// Bus between the SD init/read controller and the SPI master that shifts
// its 48-bit command frames. The master modport is the SPI engine's view and
// the slave modport is the controller/card-side view.
interface sd_spi_master_if #(
  parameter int DATA_W = 48
);
  logic              spi_soft_rst_n_i;
  logic              spi_start_i;
  logic              spi_fbo_i;
  logic [1:0]        spi_clock_divider_i;
  logic [DATA_W-1:0] spi_tx_data_i;
  logic              spi_miso_i;
  logic              spi_sck_o;
  logic              spi_mosi_o;
  logic              spi_cs_n_o;
  logic [DATA_W-1:0] spi_data_o;
  logic              spi_done_o;
  logic              spi_busy_o;

  modport master (
    input  spi_soft_rst_n_i, spi_start_i, spi_fbo_i, spi_clock_divider_i,
           spi_tx_data_i, spi_miso_i,
    output spi_sck_o, spi_mosi_o, spi_cs_n_o, spi_data_o, spi_done_o, spi_busy_o
  );

  modport slave (
    output spi_soft_rst_n_i, spi_start_i, spi_fbo_i, spi_clock_divider_i,
           spi_tx_data_i, spi_miso_i,
    input  spi_sck_o, spi_mosi_o, spi_cs_n_o, spi_data_o, spi_done_o, spi_busy_o
  );
endinterface

// File: rtl/sd_spi_master.sv
// SPI mode-0 master for SD command frames: shifts one DATA_W-bit frame out on
// MOSI while capturing DATA_W bits from MISO. All pin outputs are registered
// from the current state, so every output lags the state register by one
// clock; this lag is uniform, which keeps SCK, MOSI and CS_n aligned.
module sd_spi_master #(
  parameter int DATA_W   = 48,
  parameter int DIV_BASE = 2
) (
  input  logic          spi_clk_i,
  input  logic          spi_rst_i,
  sd_spi_master_if.master bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCK_LO,
    SCK_HI,
    FINISH,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Frame datapath: loaded in LOAD, not reset (only meaningful after LOAD).
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              fbo_q, fbo_d;
  logic [1:0]        div_q, div_d;

  logic [5:0]        half_len;
  logic              half_last;
  logic              tx_bit;

  assign half_len  = 6'(DIV_BASE) << div_q;
  assign half_last = (hcnt_q == half_len - 6'd1);
  assign tx_bit    = fbo_q ? tx_sh_q[DATA_W-1] : tx_sh_q[0];

  // Next-state, shift-register and registered-output computation.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_d      = rx_q;
    fbo_d     = fbo_q;
    div_d     = div_q;
    data_d    = data_q;
    sck_d     = 1'b0;
    mosi_d    = 1'b1;
    cs_n_d    = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.spi_start_i) state_d = LOAD;
      end

      LOAD: begin
        tx_sh_d   = bus.spi_tx_data_i;
        fbo_d     = bus.spi_fbo_i;
        div_d     = bus.spi_clock_divider_i;
        bit_cnt_d = '0;
        hcnt_d    = '0;
        cs_n_d    = 1'b0;
        busy_d    = 1'b1;
        mosi_d    = bus.spi_fbo_i ? bus.spi_tx_data_i[DATA_W-1] : bus.spi_tx_data_i[0];
        state_d   = SCK_LO;
      end

      SCK_LO: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        mosi_d = tx_bit;
        if (half_last) begin
          hcnt_d  = '0;
          state_d = SCK_HI;
        end else begin
          hcnt_d = hcnt_q + 6'd1;
        end
      end

      SCK_HI: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        mosi_d = tx_bit;
        sck_d  = 1'b1;
        // First cycle of the high phase is the edge where SCK rises.
        if (hcnt_q == 6'd0) begin
          rx_d = fbo_q ? {rx_q[DATA_W-2:0], bus.spi_miso_i}
                       : {bus.spi_miso_i, rx_q[DATA_W-1:1]};
        end
        if (half_last) begin
          hcnt_d    = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          tx_sh_d   = fbo_q ? {tx_sh_q[DATA_W-2:0], 1'b1}
                            : {1'b1, tx_sh_q[DATA_W-1:1]};
          state_d   = (bit_cnt_q == CNT_W'(DATA_W - 1)) ? FINISH : SCK_LO;
        end else begin
          hcnt_d = hcnt_q + 6'd1;
        end
      end

      FINISH: begin
        // Hold CS low for one more half-period after the last SCK fall.
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        if (half_last) begin
          hcnt_d  = '0;
          state_d = DONE;
        end else begin
          hcnt_d = hcnt_q + 6'd1;
        end
      end

      DONE: begin
        done_d = 1'b1;
        if (!done_q) data_d = rx_q;
      end

      default: state_d = IDLE;
    endcase

    // Soft clear aborts anything in flight; the received frame is kept.
    if (!bus.spi_soft_rst_n_i) begin
      state_d   = IDLE;
      hcnt_d    = '0;
      bit_cnt_d = '0;
      data_d    = data_q;
      sck_d     = 1'b0;
      mosi_d    = 1'b1;
      cs_n_d    = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  // Control state and pin outputs, with synchronous reset.
  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_q    <= data_d;
    end
  end

  // Frame shift registers and latched transfer settings.
  always_ff @(posedge spi_clk_i) begin
    tx_sh_q <= tx_sh_d;
    rx_q    <= rx_d;
    fbo_q   <= fbo_d;
    div_q   <= div_d;
  end

  assign bus.spi_sck_o  = sck_q;
  assign bus.spi_mosi_o = mosi_q;
  assign bus.spi_cs_n_o = cs_n_q;
  assign bus.spi_data_o = data_q;
  assign bus.spi_done_o = done_q;
  assign bus.spi_busy_o = busy_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: loopback and patterned MISO frames,
// divider timing, held-start and soft-reset handshakes, abort and hard reset.
module tb_sd_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_spi_master_if #(.DATA_W(48)) bus ();

  sd_spi_master #(.DATA_W(48), .DIV_BASE(2)) dut (
    .spi_clk_i (clk),
    .spi_rst_i (rst),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  int   rise_cnt  = 0;
  int   cs_bad    = 0;
  int   pat_base  = 0;
  logic loop_mode = 1'b1;
  logic pat_bit;

  assign pat_bit        = (((rise_cnt - pat_base) & 1) == 0);
  assign bus.spi_miso_i = loop_mode ? bus.spi_mosi_o : pat_bit;

  // Count SCK rising edges and flag any that happen with CS deasserted.
  always @(posedge bus.spi_sck_o) begin
    rise_cnt <= rise_cnt + 1;
    if (bus.spi_cs_n_o) cs_bad <= cs_bad + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle soft-clear pulse, as the controller issues after done.
  task automatic soft_pulse();
    @(negedge clk);
    bus.spi_soft_rst_n_i = 1'b0;
    @(negedge clk);
    bus.spi_soft_rst_n_i = 1'b1;
  endtask

  // Start a frame and count clocks from the edge that samples start until
  // done is seen; cyc = -1 when the cycle budget runs out.
  task automatic run_frame(input logic [47:0] tx, input logic fbo, input logic [1:0] code,
                           input logic loop, input logic hold_start,
                           output int cyc, output int rises, output int bad,
                           output logic first_mosi);
    int base;
    int bad0;
    cyc        = -1;
    first_mosi = 1'bx;
    @(negedge clk);
    loop_mode               = loop;
    pat_base                = rise_cnt;
    base                    = rise_cnt;
    bad0                    = cs_bad;
    bus.spi_tx_data_i       = tx;
    bus.spi_fbo_i           = fbo;
    bus.spi_clock_divider_i = code;
    bus.spi_start_i         = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) first_mosi = bus.spi_mosi_o;
      if (k == 2 && !hold_start) bus.spi_start_i = 1'b0;
      if (k == 40) begin
        bus.spi_tx_data_i = 48'h0;
        bus.spi_fbo_i     = ~fbo;
      end
      if (bus.spi_done_o) begin
        cyc = k;
        break;
      end
    end
    rises = rise_cnt - base;
    bad   = cs_bad - bad0;
  endtask

  int   cyc;
  int   rises;
  int   bad;
  logic fm;

  initial begin
    bus.spi_soft_rst_n_i    = 1'b1;
    bus.spi_start_i         = 1'b0;
    bus.spi_fbo_i           = 1'b1;
    bus.spi_clock_divider_i = 2'b00;
    bus.spi_tx_data_i       = 48'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck",  64'(bus.spi_sck_o),  64'd0);
    chk("rst_mosi", 64'(bus.spi_mosi_o), 64'd1);
    chk("rst_cs_n", 64'(bus.spi_cs_n_o), 64'd1);
    chk("rst_done", 64'(bus.spi_done_o), 64'd0);
    chk("rst_busy", 64'(bus.spi_busy_o), 64'd0);
    chk("rst_data", 64'(bus.spi_data_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Loopback, MSB first, code 00; tx changes mid-frame must be ignored
    run_frame(48'h400000000095, 1'b1, 2'b00, 1'b1, 1'b0, cyc, rises, bad, fm);
    chk("t1_cycles", 64'(cyc),   64'd196);
    chk("t1_rises",  64'(rises), 64'd48);
    chk("t1_cs_low", 64'(bad),   64'd0);
    chk("t1_first_mosi", 64'(fm), 64'd0);
    chk("t1_data", 64'(bus.spi_data_o), 64'h400000000095);
    chk("t1_cs_n_done", 64'(bus.spi_cs_n_o), 64'd1);
    chk("t1_busy_done", 64'(bus.spi_busy_o), 64'd0);

    // Alternating MISO, LSB first: first received bit lands in bit 0
    soft_pulse();
    run_frame(48'h48000001AA87, 1'b0, 2'b00, 1'b0, 1'b0, cyc, rises, bad, fm);
    chk("t2_first_mosi", 64'(fm), 64'd1);
    chk("t2_cycles", 64'(cyc), 64'd196);
    chk("t2_data", 64'(bus.spi_data_o), 64'h555555555555);

    // Slowest divider, loopback of all ones; start left high afterwards
    soft_pulse();
    run_frame(48'hFFFFFFFFFFFF, 1'b1, 2'b11, 1'b1, 1'b1, cyc, rises, bad, fm);
    chk("t3_cycles", 64'(cyc),   64'd1554);
    chk("t3_rises",  64'(rises), 64'd48);
    chk("t3_data", 64'(bus.spi_data_o), 64'hFFFFFFFFFFFF);

    // Held start does not retrigger; soft pulse clears done, LOAD follows
    repeat (20) @(posedge clk);
    #1;
    chk("t4_hold_cs_n", 64'(bus.spi_cs_n_o), 64'd1);
    chk("t4_hold_done", 64'(bus.spi_done_o), 64'd1);
    @(negedge clk);
    bus.spi_tx_data_i       = 48'h123456789ABC;
    bus.spi_fbo_i           = 1'b1;
    bus.spi_clock_divider_i = 2'b11;
    bus.spi_soft_rst_n_i    = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_done_clr", 64'(bus.spi_done_o), 64'd0);
    chk("t4_cs_n_s0",  64'(bus.spi_cs_n_o), 64'd1);
    @(negedge clk);
    bus.spi_soft_rst_n_i = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_cs_n_s1", 64'(bus.spi_cs_n_o), 64'd1);
    @(posedge clk);
    #1;
    chk("t4_cs_n_s2", 64'(bus.spi_cs_n_o), 64'd0);
    chk("t4_busy_s2", 64'(bus.spi_busy_o), 64'd1);

    // Abort after 20 SCK rising edges; previous frame must survive
    begin
      int base;
      int k;
      base = rise_cnt;
      for (k = 0; k < 2000; k++) begin
        @(posedge clk);
        #1;
        if (rise_cnt - base >= 20) break;
      end
      chk("t5_rises_before_abort", 64'(rise_cnt - base), 64'd20);
    end
    @(negedge clk);
    bus.spi_soft_rst_n_i = 1'b0;
    bus.spi_start_i      = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_cs_n", 64'(bus.spi_cs_n_o), 64'd1);
    chk("t5_sck",  64'(bus.spi_sck_o),  64'd0);
    chk("t5_busy", 64'(bus.spi_busy_o), 64'd0);
    chk("t5_done", 64'(bus.spi_done_o), 64'd0);
    chk("t5_data", 64'(bus.spi_data_o), 64'hFFFFFFFFFFFF);
    @(negedge clk);
    bus.spi_soft_rst_n_i = 1'b1;

    // Hard reset in the middle of a frame
    @(negedge clk);
    bus.spi_clock_divider_i = 2'b00;
    bus.spi_tx_data_i       = 48'hA5A5A5A5A5A5;
    bus.spi_start_i         = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("t6_busy_mid", 64'(bus.spi_busy_o), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_sck",  64'(bus.spi_sck_o),  64'd0);
    chk("t6_mosi", 64'(bus.spi_mosi_o), 64'd1);
    chk("t6_cs_n", 64'(bus.spi_cs_n_o), 64'd1);
    chk("t6_busy", 64'(bus.spi_busy_o), 64'd0);
    chk("t6_done", 64'(bus.spi_done_o), 64'd0);
    chk("t6_data", 64'(bus.spi_data_o), 64'd0);
    @(negedge clk);
    rst             = 1'b0;
    bus.spi_start_i = 1'b0;

    // start together with soft clear: clear wins, no LOAD
    @(negedge clk);
    bus.spi_start_i      = 1'b1;
    bus.spi_soft_rst_n_i = 1'b0;
    @(negedge clk);
    bus.spi_start_i      = 1'b0;
    bus.spi_soft_rst_n_i = 1'b1;
    @(posedge clk);
    #1;
    chk("t7_busy", 64'(bus.spi_busy_o), 64'd0);
    chk("t7_cs_n", 64'(bus.spi_cs_n_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_spi_master.md
Name: sd_spi_master

Overview:
- SPI mode-0 master shifting one 48-bit SD command frame out on MOSI while capturing 48 bits from MISO.
- Sits directly downstream of the SD init/read controller FSM.
- Consumes the controller's instruction word, start, bit-order, clock-divider and active-low soft-reset outputs.
- Returns the received frame, the done flag and the SCK monitor that the controller edge-detects.

Parameters:
- DATA_W, 48, frame length in bits. Fixed: the controller interface is 48-bit.
- DIV_BASE, 2, system clocks per SCK half-period at divider code 00.

Ports:
- spi_clk_i  input  1  system clock; all logic is on the rising edge.
- spi_rst_i  input  1  reset; synchronous, active-high.
- spi_soft_rst_n_i  input  1  active-low soft clear/abort, driven by the controller's spi_rst_o.
- spi_start_i  input  1  level-sensitive transfer request.
- spi_fbo_i  input  1  bit order: 1 = MSB first, 0 = LSB first.
- spi_clock_divider_i  input  2  SCK half-period H = DIV_BASE << code (2/4/8/16 clocks).
- spi_tx_data_i  input  48  frame to transmit (the controller's instruction_sd_o).
- spi_miso_i  input  1  card data out.
- spi_sck_o  output  1  SPI clock; idles low. Also fed back to the controller as spi_SCK_i.
- spi_mosi_o  output  1  card data in; idles high.
- spi_cs_n_o  output  1  card chip select, active-low.
- spi_data_o  output  48  last completed received frame.
- spi_done_o  output  1  sticky transfer-complete flag.
- spi_busy_o  output  1  high while a transfer is in progress.

Behaviour:
- Reset (spi_rst_i=1 at a clock edge): state IDLE, sck 0, mosi 1, cs_n 1, done 0, busy 0, data_o 0, all counters 0. Reset overrides all other inputs, including mid-transfer.
- States: IDLE, LOAD, SCK_LO, SCK_HI, FINISH, DONE.
- IDLE:
  - If start=1 and soft_rst_n=1, go to LOAD.
  - cs_n=1, sck=0, mosi=1.
- LOAD (1 cycle):
  - Latch tx_data, fbo and divider code; changes to these inputs during the transfer are ignored.
  - cs_n=0, busy=1, bit count=0.
  - mosi = tx[47] if fbo=1, tx[0] if fbo=0.
  - Go to SCK_LO.
- SCK_LO (H cycles): sck=0, then go to SCK_HI.
- SCK_HI (H cycles):
  - sck=1.
  - On the SCK rising edge (entry to SCK_HI), sample MISO into the rx shift register:
    - fbo=1: shift left, insert at bit 0, so the first bit lands in [47].
    - fbo=0: shift right, insert at bit 47, so the first bit lands in [0].
  - At the end of the phase, sck falls, the count increments and the next tx bit is presented on mosi.
  - If count == 48, go to FINISH; otherwise go to SCK_LO.
- FINISH (H cycles): sck=0, cs_n stays 0 (CS hold time), then go to DONE.
- DONE:
  - cs_n=1, mosi=1, busy=0, done=1.
  - data_o is loaded with the rx register on entry and is otherwise stable.
  - Remain in DONE while soft_rst_n=1, even if start stays high. This prevents retriggering on a held start level.
- Soft reset (soft_rst_n=0 at a clock edge, any state except reset):
  - Go to IDLE; done 0, busy 0, cs_n 1, sck 0, mosi 1.
  - data_o retains its value.
  - A transfer in progress is aborted with no partial update of data_o.
- start and soft_rst_n=0 in the same cycle: soft reset wins, go to IDLE.
- Timing:
  - A transfer is 96 SCK half-periods with exactly 48 rising edges.
  - done rises (2 + 97*H) clocks after the first edge that samples start=1 in IDLE: 196 for code 00, 1554 for code 11.
- Controller protocol: the controller pulses soft_rst_n low for 1 cycle when it sees done, then holds start high. This gives back-to-back frames, with a new LOAD 2 cycles after the soft-reset cycle.

Test Plan:
- MISO looped to MOSI, tx=0x400000000095, fbo=1, code 00 -> data_o=0x400000000095; 48 sck rising edges; done at cycle 196; cs_n low throughout the frame.
- MISO driven 1,0,1,0… (bit order as received), fbo=0, tx=0x48000001AA87 -> first MOSI bit =1 (tx[0]); data_o=0x555555555555; bit 0 = first received bit.
- Code 11, fbo=1, loopback tx=0xFFFFFFFFFFFF -> sck half-period 16 clocks; done at 1554; data_o=0xFFFFFFFFFFFF.
- start held high after done -> no second frame (cs_n stays 1); one-cycle soft_rst_n=0 -> done clears; second frame LOADs 2 cycles later.
- soft_rst_n=0 after 20 SCK edges -> IDLE next cycle, cs_n=1, sck=0, data_o unchanged from the previous frame.
- spi_rst_i=1 mid-frame -> next edge: all outputs at reset values, data_o=0.
